// File: rtl/access_requester.sv
// Initiator side of the key/access-check handshake: encodes a host credential into a salted key,
// strobes it into the controller, samples the verdict, scrubs the key slot and enforces lockout.
module access_requester #(
  parameter int                FH_S       = 32,
  parameter int                KH_S       = 2 * FH_S,
  parameter int                DT_S       = 3,
  parameter logic [FH_S-1:0]   DEHASH_KEY = 32'hDEADBEEF,
  parameter int                SETTLE_CYC = 1,
  parameter int                LOCK_TH    = 4,
  parameter int                LOCK_CYC   = 16,
  localparam int               DC_W       = $clog2(LOCK_TH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FH_S-1:0]   req_cred,
  input  logic [FH_S-1:0]   req_salt,
  input  logic [DT_S-1:0]   req_type,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_grant,
  output logic              rsp_locked,
  output logic [KH_S-1:0]   key_hash,
  output logic              key_en,
  output logic [DT_S-1:0]   acc_req_type,
  input  logic              access_en,
  output logic              lock_active,
  output logic [DC_W-1:0]   deny_cnt
);

  localparam int LC_W = $clog2(LOCK_CYC + 1);
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_RESP, S_SCRUB
  } state_t;

  state_t            state, state_nxt;
  logic [FH_S-1:0]   cred_q, salt_q;
  logic [DT_S-1:0]   type_q;
  logic              loaded_q;
  logic [SC_W-1:0]   settle_q;
  logic              grant_q, locked_q;
  logic [DC_W-1:0]   deny_q;
  logic [LC_W-1:0]   lock_q;
  logic              accept, key_live, deny_trip;

  assign accept      = req_valid && req_ready;
  assign lock_active = (lock_q != '0);
  assign deny_trip   = (state == S_SAMPLE) && !access_en && (deny_q == DC_W'(LOCK_TH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = lock_active ? S_RESP : S_LOAD;
      S_LOAD:   state_nxt = S_SETTLE;
      S_SETTLE: if (settle_q == SC_W'(SETTLE_CYC - 1)) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = loaded_q ? S_SCRUB : S_IDLE;
      S_SCRUB:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Key stays on the bus from load until the scrub overwrites it; locked rejects never drive it.
  always_comb begin
    req_ready    = (state == S_IDLE) && !rst;
    rsp_valid    = (state == S_RESP);
    key_en       = (state == S_LOAD) || (state == S_SCRUB);
    key_live     = loaded_q && ((state == S_LOAD) || (state == S_SETTLE) ||
                                (state == S_SAMPLE) || (state == S_RESP));
    key_hash     = '0;
    acc_req_type = '0;
    if (key_live) begin
      key_hash     = {salt_q, salt_q ^ cred_q ^ DEHASH_KEY};
      acc_req_type = type_q;
    end
  end

  assign rsp_grant  = grant_q;
  assign rsp_locked = locked_q;
  assign deny_cnt   = deny_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cred_q   <= '0;
      salt_q   <= '0;
      type_q   <= '0;
      loaded_q <= 1'b0;
      settle_q <= '0;
      grant_q  <= 1'b0;
      locked_q <= 1'b0;
      deny_q   <= '0;
      lock_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cred_q   <= req_cred;
        salt_q   <= req_salt;
        type_q   <= req_type;
        loaded_q <= !lock_active;
        grant_q  <= 1'b0;
        locked_q <= lock_active;
      end
      if (state == S_SETTLE) settle_q <= settle_q + 1'b1;
      else                   settle_q <= '0;
      if (state == S_SAMPLE) begin
        grant_q  <= access_en;
        locked_q <= 1'b0;
        if (access_en || deny_trip) deny_q <= '0;
        else                        deny_q <= deny_q + 1'b1;
      end
      if (deny_trip)            lock_q <= LC_W'(LOCK_CYC);
      else if (lock_q != '0)    lock_q <= lock_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_access_requester.sv
// Self-checking bench for access_requester: directed scenarios plus randomized transactions
// scored against a transaction-level model (absolute-cycle lock expiry, denial counter).
module tb_access_requester;

  localparam logic [31:0] DK = 32'hDEADBEEF;
  localparam int S  = 1;
  localparam int TH = 4;
  localparam int LC = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default-parameter DUT
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_grant, rsp_locked;
  logic        key_en, access_en, lock_active;
  logic [31:0] req_cred, req_salt;
  logic [2:0]  req_type, acc_req_type;
  logic [63:0] key_hash;
  logic [2:0]  deny_cnt;

  access_requester dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cred(req_cred), .req_salt(req_salt), .req_type(req_type),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_grant(rsp_grant),
    .rsp_locked(rsp_locked), .key_hash(key_hash), .key_en(key_en),
    .acc_req_type(acc_req_type), .access_en(access_en),
    .lock_active(lock_active), .deny_cnt(deny_cnt)
  );

  // longer settle window build
  logic        req_valid3, req_ready3, rsp_valid3, rsp_grant3, rsp_locked3;
  logic        key_en3, access_en3, lock_active3;
  logic [2:0]  acc_req_type3;
  logic [63:0] key_hash3;
  logic [2:0]  deny_cnt3;

  access_requester #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_cred(req_cred), .req_salt(req_salt), .req_type(req_type),
    .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_grant(rsp_grant3),
    .rsp_locked(rsp_locked3), .key_hash(key_hash3), .key_en(key_en3),
    .acc_req_type(acc_req_type3), .access_en(access_en3),
    .lock_active(lock_active3), .deny_cnt(deny_cnt3)
  );

  int checks = 0;
  int failures = 0;

  // model state
  int m_deny = 0;
  int m_lock_until = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [31:0] c, input logic [31:0] s, input logic [2:0] t,
                     input logic ae, input int hold);
    logic        lk;
    logic [63:0] kh;
    lk = (cyc < m_lock_until);
    kh = {s, s ^ c ^ DK};
    chk("idle_ready", req_ready, 1);
    req_valid = 1; req_cred = c; req_salt = s; req_type = t; access_en = ~ae;
    step();
    req_valid = 0;
    if (!lk) begin
      chk("load_key_en", key_en, 1);
      chk("load_hash", key_hash, kh);
      chk("load_type", acc_req_type, t);
      chk("busy_ready", req_ready, 0);
      for (int i = 0; i < S; i++) begin
        step();
        chk("settle_key_en", key_en, 0);
        chk("settle_hash", key_hash, kh);
        chk("settle_rsp_valid", rsp_valid, 0);
      end
      step();
      access_en = ae;
      chk("sample_rsp_valid", rsp_valid, 0);
      step();
      access_en = ~ae;
      if (ae) m_deny = 0;
      else begin
        m_deny++;
        if (m_deny == TH) begin
          m_deny = 0;
          m_lock_until = cyc + LC;
        end
      end
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_grant", rsp_grant, lk ? 1'b0 : ae);
    chk("rsp_locked", rsp_locked, lk);
    chk("rsp_key_en", key_en, 0);
    chk("deny_cnt", deny_cnt, m_deny);
    chk("lock_active", lock_active, cyc < m_lock_until);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_grant", rsp_grant, lk ? 1'b0 : ae);
      chk("hold_locked", rsp_locked, lk);
      chk("hold_ready", req_ready, 0);
      chk("hold_key_en", key_en, 0);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    if (!lk) begin
      chk("scrub_key_en", key_en, 1);
      chk("scrub_hash", key_hash, 0);
      chk("scrub_type", acc_req_type, 0);
      chk("scrub_rsp_valid", rsp_valid, 0);
      step();
    end
    chk("end_key_en", key_en, 0);
    chk("end_ready", req_ready, 1);
    chk("end_hash", key_hash, 0);
    chk("end_rsp_valid", rsp_valid, 0);
  endtask

  task automatic txn3(input logic ae_settle, input logic ae_sample);
    req_valid3 = 1; req_cred = $urandom; req_salt = $urandom; req_type = 3'($urandom);
    access_en3 = ae_settle;
    step();
    req_valid3 = 0;
    chk("s3_load_key_en", key_en3, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_settle_rsp_valid", rsp_valid3, 0);
      chk("s3_settle_key_en", key_en3, 0);
    end
    step();
    access_en3 = ae_sample;
    chk("s3_sample_rsp_valid", rsp_valid3, 0);
    step();
    access_en3 = ae_settle;
    chk("s3_rsp_valid_t6", rsp_valid3, 1);
    chk("s3_grant", rsp_grant3, ae_sample);
    step();
    chk("s3_scrub_key_en", key_en3, 1);
    chk("s3_scrub_hash", key_hash3, 0);
    step();
    chk("s3_idle_ready", req_ready3, 1);
  endtask

  initial begin
    rst = 1; req_valid = 0; rsp_ready = 0; access_en = 0;
    req_cred = '0; req_salt = '0; req_type = '0;
    req_valid3 = 0; access_en3 = 0;
    step(); step();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_key_en", key_en, 0);
    chk("rst_hash", key_hash, 0);
    chk("rst_lock", lock_active, 0);
    chk("rst_deny", deny_cnt, 0);
    chk("rst_grant", rsp_grant, 0);
    rst = 0;
    step();

    // encoding example and grant, then one denial cleared by a grant
    txn(32'hABCDABCD, 32'h12345678, 3'd2, 1'b1, 0);
    chk("ex_hash_const", {32'h12345678, 32'h12345678 ^ 32'hABCDABCD ^ DK}, 64'h12345678_6754435A);
    txn(32'hABCDABCD, 32'h12345678, 3'd2, 1'b0, 0);
    txn(32'hABCDABCD, 32'h12345678, 3'd2, 1'b1, 0);

    // four denials trigger lockout; fifth is rejected without a key load
    for (int i = 0; i < TH; i++) txn(32'h11110000 + i, 32'h0F0F0F0F, 3'd5, 1'b0, 0);
    chk("lock_set", lock_active, 1);
    txn(32'h22222222, 32'h33333333, 3'd1, 1'b1, 1);
    while (cyc <= m_lock_until) begin
      chk("lock_window", lock_active, cyc < m_lock_until);
      step();
    end

    // long response backpressure
    txn(32'hCAFEF00D, 32'h5A5A5A5A, 3'd7, 1'b1, 10);

    // reset during settle aborts with no response
    req_valid = 1; req_cred = 32'h01234567; req_salt = 32'h89ABCDEF; req_type = 3'd3;
    step();
    req_valid = 0;
    step();
    rst = 1;
    step();
    chk("abort_key_en", key_en, 0);
    chk("abort_hash", key_hash, 0);
    chk("abort_type", acc_req_type, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_deny", deny_cnt, 0);
    rst = 0;
    m_deny = 0; m_lock_until = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_no_key", key_en, 0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      txn($urandom, $urandom, 3'($urandom), 1'($urandom_range(0, 2) != 0 ? 0 : 1),
          $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        chk("gap_lock", lock_active, cyc < m_lock_until);
      end
    end

    // settle-window build: verdict comes from the sample cycle only
    txn3(1'b0, 1'b1);
    txn3(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
